commu_tx_arb: RTL and testbench
===============================

# commu_tx_arb

Frame-level arbiter sharing the single `commu_tx_inf` serializer among three transmit requesters: 0 = data frame sequencer (head/push/tail mux output), 1 = status/heartbeat responder, 2 = register read-back reply. It grants the serializer to one requester for a whole frame using round-robin selection. It routes that requester's word handshakes to the serializer and inserts a programmable bus-turnaround gap between frames. A watchdog recovers the serializer from a stalled owner.

## Interface
Parameters:
- `GAP_W`, 16: width of gap and watchdog counters.

Ports:
- `clk_sys`  in  1  system clock; every register updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  3  per-requester frame request level; held high for the whole frame, dropped to release.
- `fire_tx_in`  in  3  per-requester word-start pulse.
- `data_tx_0`, `data_tx_1`, `data_tx_2`  in  16 each  per-requester word data, valid with the matching `fire_tx_in` bit.
- `done_tx`  in  1  serializer word-complete pulse.
- `arb_en`  in  1  enables new grants.
- `cfg_gap`  in  GAP_W  idle cycles inserted after each frame.
- `cfg_wdt`  in  GAP_W  watchdog limit in cycles; 0 disables the watchdog.
- `gnt`  out  3  one-hot grant, registered.
- `done_tx_out`  out  3  word-complete pulse routed to the owner.
- `fire_tx`  out  1  word-start pulse to the serializer.
- `data_tx`  out  16  word to the serializer.
- `err_wdt`  out  1  one-cycle pulse on watchdog expiry.
- `cnt_err`  out  8  saturating count of watchdog expiries.

## Operation
- States are IDLE, GRANT, BUSY and GAP. `owner` (2 bits) is the granted requester. `last` (2 bits) is the most recent winner.
- IDLE:
  - `gnt` = 0.
  - If `arb_en`=1 and `req`≠0, the winner is the first set `req` bit scanning `last+1, last+2, last` (mod 3).
  - On a win: `owner` = winner, `last` = winner, `gnt` one-hot set; go to GRANT.
- GRANT:
  - `fire_tx_in[owner]`=1: latch `data_tx_<owner>` into `data_tx`, pulse `fire_tx`, go to BUSY.
  - Otherwise, `req[owner]`=0: clear `gnt`, load the gap counter, go to GAP.
  - `fire_tx_in` bits from non-owners are ignored at all times.
- BUSY:
  - `done_tx`=1: pulse `done_tx_out[owner]`.
  - On that done, if `req[owner]`=1, go to GRANT. If `req[owner]`=0, clear `gnt` and go to GAP.
- GAP:
  - Count `cfg_gap` cycles, then go to IDLE.
  - With `cfg_gap`=0, go to IDLE on the next cycle.
- Watchdog:
  - The counter clears on entry to GRANT or BUSY, on `fire_tx`, and on `done_tx`. It increments in GRANT and BUSY.
  - If `cfg_wdt`≠0 and the counter reaches `cfg_wdt`:
    - pulse `err_wdt`;
    - `cnt_err` += 1, saturating at 255;
    - clear `gnt`, go to GAP.
- `arb_en`=0 blocks only the IDLE→GRANT transition. A frame in progress completes normally.
- `done_tx` arriving outside BUSY is ignored; `done_tx_out` stays 0.
- `data_tx` holds its last value between words.

## Timing
- Reset values: state IDLE, `gnt`=0, `fire_tx`=0, `data_tx`=0, `done_tx_out`=0, `err_wdt`=0, `cnt_err`=0, `last`=2 (so requester 0 wins first), watchdog and gap counters 0.
- Latencies:
  - `req` rise in IDLE → `gnt` high next cycle.
  - `fire_tx_in[owner]` → `fire_tx` and `data_tx` 1 cycle later.
  - `done_tx` → `done_tx_out[owner]` 1 cycle later.
- Simultaneous events:
  - `fire_tx_in[owner]` and `req[owner]` drop in the same GRANT cycle: the word is sent, release follows its done.
  - `done_tx` and `req[owner]` drop in the same cycle: `done_tx_out` pulses and the state goes to GAP.
  - Watchdog expiry and `done_tx` in the same cycle: `done_tx` wins and the watchdog clears.
- A frame with no words (`req` up then down with no fire) still costs the GAP.
- Minimum spacing between grants: `cfg_gap`+2 cycles.
- Reset asserted mid-frame returns every output to its reset value immediately. No `done_tx_out` is emitted for the aborted word.

## Test plan
- **Single frame:** `req[1]` held through 3 words with `cfg_gap`=4. Expect `gnt`=3'b010 one cycle after `req`, 3 `fire_tx` pulses carrying `data_tx_1` values, 3 `done_tx_out[1]` pulses, `gnt`=0 after release, and no new grant for 4 cycles.
- **Round-robin:** all three `req` high continuously, each frame 1 word. Grant order is 0, 1, 2, 0.
- **Isolation:** `fire_tx_in[2]` pulsed while requester 0 owns the bus. Expect no `fire_tx` and no `done_tx_out[2]`.
- **Watchdog:** `cfg_wdt`=10, owner fires one word, `done_tx` withheld. Expect `err_wdt` pulse exactly 10 cycles after `fire_tx`, `gnt`=0, `cnt_err`=1. A later `done_tx` is ignored.
- **Counter saturation:** 260 forced watchdog expiries → `cnt_err`=255.
- **Enable and reset:** `arb_en`=0 while `req[0]`=1 gives no grant; raising `arb_en` gives a grant next cycle. Asserting `rst_n`=0 during BUSY clears all outputs asynchronously. After release, requester 0 wins first.

Source files
------------

// File: rtl/commu_tx_arb_if.sv
// Word/frame handshake bundle between three transmit requesters, the
// frame arbiter and the shared commu_tx_inf serializer.
interface commu_tx_arb_if;
  logic [2:0]  req;
  logic [2:0]  fire_tx_in;
  logic [15:0] data_tx_0;
  logic [15:0] data_tx_1;
  logic [15:0] data_tx_2;
  logic        done_tx;
  logic [2:0]  gnt;
  logic [2:0]  done_tx_out;
  logic        fire_tx;
  logic [15:0] data_tx;

  modport slave (
    input  req, fire_tx_in, data_tx_0, data_tx_1, data_tx_2, done_tx,
    output gnt, done_tx_out, fire_tx, data_tx
  );

  modport master (
    output req, fire_tx_in, data_tx_0, data_tx_1, data_tx_2, done_tx,
    input  gnt, done_tx_out, fire_tx, data_tx
  );
endinterface

// File: rtl/commu_tx_arb.sv
// Round-robin frame arbiter for the shared transmit serializer, with a
// post-frame turnaround gap and a stalled-owner watchdog.
module commu_tx_arb #(
  parameter int GAP_W = 16
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  commu_tx_arb_if.slave      bus,
  input  logic               arb_en,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic [GAP_W-1:0]   cfg_wdt,
  output logic               err_wdt,
  output logic [7:0]         cnt_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [GAP_W-1:0] CNT_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] CNT_ZERO = {GAP_W{1'b0}};

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    case (idx)
      2'd0:    rr_next = 2'd1;
      2'd1:    rr_next = 2'd2;
      default: rr_next = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] idx);
    case (idx)
      2'd0:    one_hot = 3'b001;
      2'd1:    one_hot = 3'b010;
      default: one_hot = 3'b100;
    endcase
  endfunction

  // Scan last+1, last+2, last so the previous winner has lowest priority.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = rr_next(l);
    c2 = rr_next(c1);
    if (r[c1]) begin
      rr_pick = c1;
    end else if (r[c2]) begin
      rr_pick = c2;
    end else begin
      rr_pick = l;
    end
  endfunction

  state_t            state_r,   state_s;
  logic [1:0]        owner_r,   owner_s;
  logic [1:0]        last_r,    last_s;
  logic [2:0]        gnt_r,     gnt_s;
  logic              fire_r,    fire_s;
  logic [15:0]       data_r,    data_s;
  logic [2:0]        dout_r,    dout_s;
  logic              err_r,     err_s;
  logic [7:0]        cnt_err_r, cnt_err_s;
  logic [GAP_W-1:0]  wdt_r,     wdt_s;
  logic [GAP_W-1:0]  gap_r,     gap_s;

  logic [1:0]        win_s;
  logic              req_own_s;
  logic              fire_own_s;
  logic [15:0]       data_sel_s;
  logic [GAP_W-1:0]  wdt_inc_s;
  logic              wdt_hit_s;
  logic [7:0]        cnt_sat_s;

  assign win_s      = rr_pick(bus.req, last_r);
  assign req_own_s  = bus.req[owner_r];
  assign fire_own_s = bus.fire_tx_in[owner_r];
  assign wdt_inc_s  = wdt_r + CNT_ONE;
  assign wdt_hit_s  = (cfg_wdt != CNT_ZERO) && (wdt_inc_s == cfg_wdt);
  assign cnt_sat_s  = (cnt_err_r == 8'hFF) ? 8'hFF : (cnt_err_r + 8'd1);

  // Owner's word data mux toward the serializer.
  always_comb begin
    case (owner_r)
      2'd0:    data_sel_s = bus.data_tx_0;
      2'd1:    data_sel_s = bus.data_tx_1;
      default: data_sel_s = bus.data_tx_2;
    endcase
  end

  // Next-state and next-output logic; watchdog clears unless it keeps counting.
  always_comb begin
    state_s   = state_r;
    owner_s   = owner_r;
    last_s    = last_r;
    gnt_s     = gnt_r;
    fire_s    = 1'b0;
    data_s    = data_r;
    dout_s    = 3'b000;
    err_s     = 1'b0;
    cnt_err_s = cnt_err_r;
    wdt_s     = CNT_ZERO;
    gap_s     = gap_r;
    case (state_r)
      ST_IDLE: begin
        gnt_s = 3'b000;
        if (arb_en && (bus.req != 3'b000)) begin
          owner_s = win_s;
          last_s  = win_s;
          gnt_s   = one_hot(win_s);
          state_s = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (fire_own_s) begin
          data_s  = data_sel_s;
          fire_s  = 1'b1;
          state_s = ST_BUSY;
        end else if (!req_own_s) begin
          gnt_s   = 3'b000;
          gap_s   = cfg_gap;
          state_s = ST_GAP;
        end else if (wdt_hit_s) begin
          gnt_s     = 3'b000;
          gap_s     = cfg_gap;
          err_s     = 1'b1;
          cnt_err_s = cnt_sat_s;
          state_s   = ST_GAP;
        end else begin
          wdt_s = wdt_inc_s;
        end
      end
      ST_BUSY: begin
        // A completing word beats a simultaneous watchdog expiry.
        if (bus.done_tx) begin
          dout_s = one_hot(owner_r);
          if (req_own_s) begin
            state_s = ST_GRANT;
          end else begin
            gnt_s   = 3'b000;
            gap_s   = cfg_gap;
            state_s = ST_GAP;
          end
        end else if (wdt_hit_s) begin
          gnt_s     = 3'b000;
          gap_s     = cfg_gap;
          err_s     = 1'b1;
          cnt_err_s = cnt_sat_s;
          state_s   = ST_GAP;
        end else begin
          wdt_s = wdt_inc_s;
        end
      end
      ST_GAP: begin
        gnt_s = 3'b000;
        if (gap_r == CNT_ZERO) begin
          state_s = ST_IDLE;
        end else begin
          gap_s = gap_r - CNT_ONE;
        end
      end
      default: begin
        gnt_s   = 3'b000;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      owner_r   <= 2'd0;
      last_r    <= 2'd2;
      gnt_r     <= 3'b000;
      fire_r    <= 1'b0;
      data_r    <= 16'h0000;
      dout_r    <= 3'b000;
      err_r     <= 1'b0;
      cnt_err_r <= 8'h00;
      wdt_r     <= CNT_ZERO;
      gap_r     <= CNT_ZERO;
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      last_r    <= last_s;
      gnt_r     <= gnt_s;
      fire_r    <= fire_s;
      data_r    <= data_s;
      dout_r    <= dout_s;
      err_r     <= err_s;
      cnt_err_r <= cnt_err_s;
      wdt_r     <= wdt_s;
      gap_r     <= gap_s;
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.fire_tx     = fire_r;
  assign bus.data_tx     = data_r;
  assign bus.done_tx_out = dout_r;
  assign err_wdt         = err_r;
  assign cnt_err         = cnt_err_r;

endmodule

// File: tb/tb_commu_tx_arb.sv
// Directed bench for commu_tx_arb: a vector table for one full frame plus
// hand-written sequences for round-robin, isolation, watchdog and reset.
module tb_commu_tx_arb;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  fin;
    logic [15:0] dat;
    logic        done;
    logic [2:0]  e_gnt;
    logic        e_fire;
    logic [15:0] e_data;
    logic [2:0]  e_dout;
  } vec_t;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        arb_en;
  logic [15:0] cfg_gap;
  logic [15:0] cfg_wdt;
  logic        err_wdt;
  logic [7:0]  cnt_err;

  int n_pass  = 0;
  int n_total = 0;

  commu_tx_arb_if bus ();

  commu_tx_arb #(.GAP_W(16)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus),
    .arb_en  (arb_en),
    .cfg_gap (cfg_gap),
    .cfg_wdt (cfg_wdt),
    .err_wdt (err_wdt),
    .cnt_err (cnt_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] f, input logic [15:0] d,
                              input logic dn, input logic [2:0] eg, input logic ef,
                              input logic [15:0] ed, input logic [2:0] eo);
    vec_t v;
    v.req = r; v.fin = f; v.dat = d; v.done = dn;
    v.e_gnt = eg; v.e_fire = ef; v.e_data = ed; v.e_dout = eo;
    return v;
  endfunction

  function automatic logic [31:0] all_outs();
    return {bus.gnt, bus.fire_tx, bus.data_tx, bus.done_tx_out, err_wdt, cnt_err};
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [2:0]  rr_oh[4];
    logic [1:0]  rr_ix[4];
    logic        early;
    int          errs;

    rst_n = 1'b0;
    arb_en = 1'b1;
    cfg_gap = 16'd4;
    cfg_wdt = 16'd0;
    bus.req = 3'b000;
    bus.fire_tx_in = 3'b000;
    bus.data_tx_0 = 16'h0000;
    bus.data_tx_1 = 16'h0000;
    bus.data_tx_2 = 16'h0000;
    bus.done_tx = 1'b0;
    #3;
    chk("reset_values", all_outs(), 32'd0);
    #9;
    rst_n = 1'b1;

    // Single frame of three words from requester 1, then an empty frame.
    tbl.push_back(mk(3'b010, 3'b000, 16'h0000, 1'b0, 3'b010, 1'b0, 16'h0000, 3'b000));
    tbl.push_back(mk(3'b010, 3'b010, 16'hA1A1, 1'b0, 3'b010, 1'b1, 16'hA1A1, 3'b000));
    tbl.push_back(mk(3'b010, 3'b000, 16'h0000, 1'b0, 3'b010, 1'b0, 16'hA1A1, 3'b000));
    tbl.push_back(mk(3'b010, 3'b000, 16'h0000, 1'b1, 3'b010, 1'b0, 16'hA1A1, 3'b010));
    tbl.push_back(mk(3'b010, 3'b010, 16'hB2B2, 1'b0, 3'b010, 1'b1, 16'hB2B2, 3'b000));
    tbl.push_back(mk(3'b010, 3'b000, 16'h0000, 1'b1, 3'b010, 1'b0, 16'hB2B2, 3'b010));
    tbl.push_back(mk(3'b010, 3'b011, 16'hC3C3, 1'b0, 3'b010, 1'b1, 16'hC3C3, 3'b000));
    tbl.push_back(mk(3'b010, 3'b000, 16'h0000, 1'b1, 3'b010, 1'b0, 16'hC3C3, 3'b010));
    tbl.push_back(mk(3'b000, 3'b000, 16'h0000, 1'b0, 3'b000, 1'b0, 16'hC3C3, 3'b000));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(3'b010, 3'b000, 16'h0000, 1'b0, 3'b000, 1'b0, 16'hC3C3, 3'b000));
    tbl.push_back(mk(3'b010, 3'b000, 16'h0000, 1'b0, 3'b010, 1'b0, 16'hC3C3, 3'b000));
    tbl.push_back(mk(3'b000, 3'b000, 16'h0000, 1'b0, 3'b000, 1'b0, 16'hC3C3, 3'b000));
    tbl.push_back(mk(3'b000, 3'b000, 16'h0000, 1'b1, 3'b000, 1'b0, 16'hC3C3, 3'b000));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(3'b000, 3'b000, 16'h0000, 1'b0, 3'b000, 1'b0, 16'hC3C3, 3'b000));

    foreach (tbl[i]) begin
      bus.req        = tbl[i].req;
      bus.fire_tx_in = tbl[i].fin;
      bus.data_tx_1  = tbl[i].dat;
      bus.data_tx_0  = tbl[i].dat ^ 16'hFFFF;
      bus.data_tx_2  = tbl[i].dat ^ 16'h0F0F;
      bus.done_tx    = tbl[i].done;
      step();
      chk($sformatf("frame_vec[%0d]", i),
          {9'd0, bus.gnt, bus.fire_tx, bus.data_tx, bus.done_tx_out},
          {9'd0, tbl[i].e_gnt, tbl[i].e_fire, tbl[i].e_data, tbl[i].e_dout});
    end
    bus.done_tx = 1'b0;

    // Round-robin from reset with one-word frames and zero gap.
    cfg_gap = 16'd0;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    bus.data_tx_0 = 16'h1000;
    bus.data_tx_1 = 16'h1001;
    bus.data_tx_2 = 16'h1002;
    rr_oh[0] = 3'b001; rr_oh[1] = 3'b010; rr_oh[2] = 3'b100; rr_oh[3] = 3'b001;
    rr_ix[0] = 2'd0;   rr_ix[1] = 2'd1;   rr_ix[2] = 2'd2;   rr_ix[3] = 2'd0;
    bus.req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 20 && bus.gnt == 3'b000; t++) step();
      chk($sformatf("rr_gnt[%0d]", k), {29'd0, bus.gnt}, {29'd0, rr_oh[k]});
      if (k == 0) begin
        bus.fire_tx_in = 3'b100;
        bus.data_tx_2 = 16'hDEAD;
        step();
        chk("iso_fire", {12'd0, bus.gnt, bus.fire_tx, bus.data_tx},
            {12'd0, 3'b001, 1'b0, 16'h0000});
        bus.data_tx_2 = 16'h1002;
      end
      bus.fire_tx_in = rr_oh[k];
      step();
      bus.fire_tx_in = 3'b000;
      chk($sformatf("rr_fire[%0d]", k), {15'd0, bus.fire_tx, bus.data_tx},
          {15'd0, 1'b1, 16'h1000 + {14'd0, rr_ix[k]}});
      step();
      bus.done_tx = 1'b1;
      bus.req = 3'b111 & ~rr_oh[k];
      step();
      bus.done_tx = 1'b0;
      chk($sformatf("rr_done[%0d]", k), {26'd0, bus.done_tx_out, bus.gnt},
          {26'd0, rr_oh[k], 3'b000});
      bus.req = 3'b111;
    end
    bus.req = 3'b000;
    for (int i = 0; i < 3; i++) step();

    // Watchdog expiry 10 cycles after the word fires; later done ignored.
    cfg_wdt = 16'd10;
    bus.req = 3'b010;
    step();
    chk("wdt_gnt", {29'd0, bus.gnt}, {29'd0, 3'b010});
    bus.fire_tx_in = 3'b010;
    bus.data_tx_1 = 16'h5A5A;
    step();
    bus.fire_tx_in = 3'b000;
    chk("wdt_fire", {15'd0, bus.fire_tx, bus.data_tx}, {15'd0, 1'b1, 16'h5A5A});
    early = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (err_wdt) early = 1'b1;
    end
    chk("wdt_early", {31'd0, early}, 32'd0);
    step();
    chk("wdt_expire", {20'd0, err_wdt, bus.gnt, cnt_err}, {20'd0, 1'b1, 3'b000, 8'd1});
    bus.req = 3'b000;
    bus.done_tx = 1'b1;
    step();
    bus.done_tx = 1'b0;
    chk("wdt_late_done", {28'd0, bus.done_tx_out, err_wdt}, 32'd0);

    // done_tx on the expiry cycle wins over the watchdog.
    cfg_wdt = 16'd3;
    step();
    bus.req = 3'b001;
    step();
    chk("dw_gnt", {29'd0, bus.gnt}, {29'd0, 3'b001});
    bus.fire_tx_in = 3'b001;
    step();
    bus.fire_tx_in = 3'b000;
    step();
    step();
    bus.done_tx = 1'b1;
    bus.req = 3'b000;
    step();
    bus.done_tx = 1'b0;
    chk("wdt_vs_done", {17'd0, bus.done_tx_out, err_wdt, bus.gnt, cnt_err},
        {17'd0, 3'b001, 1'b0, 3'b000, 8'd1});

    // Saturation of the expiry counter.
    cfg_wdt = 16'd1;
    step();
    bus.req = 3'b001;
    errs = 0;
    for (int t = 0; t < 2000 && errs < 260; t++) begin
      step();
      if (err_wdt) errs++;
    end
    chk("sat_pulses", errs, 32'd260);
    chk("sat_cnt", {24'd0, cnt_err}, {24'd0, 8'd255});
    bus.req = 3'b000;
    cfg_wdt = 16'd0;
    for (int i = 0; i < 3; i++) step();

    // Enable gating, then asynchronous reset mid-word.
    arb_en = 1'b0;
    bus.req = 3'b001;
    for (int i = 0; i < 3; i++) step();
    chk("en_block", {29'd0, bus.gnt}, 32'd0);
    arb_en = 1'b1;
    step();
    chk("en_grant", {29'd0, bus.gnt}, {29'd0, 3'b001});
    bus.fire_tx_in = 3'b001;
    bus.data_tx_0 = 16'hBEEF;
    step();
    bus.fire_tx_in = 3'b000;
    chk("en_fire", {15'd0, bus.fire_tx, bus.data_tx}, {15'd0, 1'b1, 16'hBEEF});
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", all_outs(), 32'd0);
    bus.done_tx = 1'b1;
    step();
    chk("rst_no_done", {29'd0, bus.done_tx_out}, 32'd0);
    bus.done_tx = 1'b0;
    rst_n = 1'b1;
    bus.req = 3'b111;
    step();
    chk("rst_first_win", {29'd0, bus.gnt}, {29'd0, 3'b001});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
